decimal_line_encoder: RTL and testbench
=======================================

# decimal_line_encoder

Encoder for the M161 decimal decoder: converts ten active-low digit lines (keypad, rotary switch or front-panel lines wired in the M161 output sense) into a 4-bit BCD code with a valid/ready handshake. The block synchronises and debounces the lines, priority-encodes one press, holds the code until it is consumed, and requires release before the next capture. Its code output maps onto the M161 weighted inputs, so a loopback through an M161 reproduces the asserted line.

## Interface
- `DEBOUNCE_CYCLES`, 16, stable cycles required for press and for release (≥1; counter width `$clog2(DEBOUNCE_CYCLES+1)`).
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `line_n`  in  10  active-low digit lines; bit i = digit i; asynchronous to `clk`.
- `enable`  in  1  when 0, all lines are treated as released.
- `code`  out  4  BCD digit 0–9; `code[3]`→U1 (8), `code[2]`→V2 (4), `code[1]`→U2 (2), `code[0]`→V1 (1).
- `valid`  out  1  `code` holds an unconsumed digit.
- `ready`  in  1  consumer accepts `code` when `valid & ready`.
- `multi`  out  1  more than one line was active at capture; qualifies `code`.
- `overrun`  out  1  sticky; a digit was overwritten before it was consumed.

## Operation
- Two-flop synchroniser on `line_n`, reset to all 1s. `act = ~sync2 & {10{enable}}`.
- States:
  - IDLE: if `act != 0`, load `cand = act`, clear `cnt`, go to DEBOUNCE.
  - DEBOUNCE:
    - if `act == 0`, go to IDLE;
    - else if `act != cand`, reload `cand` and clear `cnt`;
    - else if `cnt == DEBOUNCE_CYCLES-1`, capture and go to WAIT_REL;
    - else increment `cnt`.
  - WAIT_REL: any `act != 0` clears `cnt`. If `act == 0` and `cnt == DEBOUNCE_CYCLES-1`, go to IDLE; otherwise increment `cnt` while `act == 0`.
- Capture:
  - `code` = lowest set index of `cand`.
  - `multi` = (popcount(`cand`) > 1).
  - `valid` ← 1.
- Handshake: on a cycle with `valid & ready` and no capture, `valid` ← 0 at the next edge. `code` and `multi` hold their values until the next capture.
- Capture while `valid = 1` and `ready = 0`: `code` and `multi` are overwritten, `valid` stays 1, and `overrun` ← 1.
- Capture in the same cycle as `valid & ready`: the old digit is consumed, the new digit loads, `valid` stays 1, and `overrun` is unchanged.
- `overrun` clears only on `rst`.
- `enable` falling mid-DEBOUNCE makes `act = 0`, so the state returns to IDLE and nothing is captured. In WAIT_REL, `enable` low counts as release.
- `ready` while `valid = 0` is ignored.

## Timing
- All outputs are registered.
- Reset values: `code` = 0, `valid` = 0, `multi` = 0, `overrun` = 0, state IDLE, `cnt` = 0, `cand` = 0, synchroniser = 10'h3FF.
- `rst` mid-operation aborts any debounce or pending digit on the next edge.
- Press latency: if `line_n` changes before edge 1, `act` is visible after edge 2, DEBOUNCE is entered at edge 3, and capture occurs at edge 3+DEBOUNCE_CYCLES (`valid` high after that edge) when lines stay stable.
- Release: `act` must read 0 for DEBOUNCE_CYCLES consecutive cycles in WAIT_REL before IDLE. The next capture is possible no earlier than DEBOUNCE_CYCLES+1 cycles after that.
- `valid` drops exactly one edge after the accepting `valid & ready` cycle.

## Configuration
- Macro `DECIMAL_LINE_ENCODER_DEBOUNCE_EN`.
- Defined: behaviour as above.
- Undefined:
  - DEBOUNCE state and counter are removed, and `DEBOUNCE_CYCLES` is ignored.
  - IDLE captures directly from `act` on the first nonzero cycle, giving press latency 3 edges.
  - WAIT_REL returns to IDLE after a single cycle of `act == 0`.
  - Handshake, `multi` and `overrun` are unchanged.

## Test plan
- Reset, debounce defined, DEBOUNCE_CYCLES = 4: drive `line_n` = 10'h3F7 (digit 3) and hold with `ready` = 0 → `valid` rises after edge 7, `code` = 4'd3, `multi` = 0. Pulse `ready` for 1 cycle → `valid` = 0 on the next edge.
- Bounce: digit 7 active for 2 cycles, released for 1 cycle, then stable → exactly one capture, `code` = 7, timed from the start of the final stable interval.
- Multi-press: lines 2 and 9 both low and stable → `code` = 2, `multi` = 1.
- Overrun: capture digit 5, never assert `ready`, release for 4+ cycles, press digit 8 → `code` = 8, `valid` = 1, `overrun` = 1. A second sequence with `ready` high at the capture edge → `overrun` stays 0.
- `enable` dropped during DEBOUNCE, and separately `rst` asserted with `valid` = 1 → no capture in the first case; in the second, all outputs return to 0 after the `rst` edge.
- Macro undefined: digit 9 low → `valid` after edge 3 with `code` = 4'd9. Loopback `code` through `m161` with enables high → only the line-9 output is asserted.

Source files
------------

// File: rtl/decimal_line_encoder.sv
// decimal_line_encoder: ten active-low digit lines to a BCD code with valid/ready handshake.
// Lines are synchronised, priority-encoded (lowest index wins) and held until consumed;
// a release is required before the next capture.
// Build option: define DECIMAL_LINE_ENCODER_DEBOUNCE_EN to debounce press and release over
// DEBOUNCE_CYCLES stable cycles. Without it, capture and release act on the first cycle.
// code[3:0] drives the M161 weighted inputs U1 (8), V2 (4), U2 (2), V1 (1).

module decimal_line_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] line_n,
    input  logic       enable,
    output logic [3:0] code,
    output logic       valid,
    input  logic       ready,
    output logic       multi,
    output logic       overrun
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

`ifdef DECIMAL_LINE_ENCODER_DEBOUNCE_EN
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StDebounce,
        StWaitRel
    } state_e;

    logic [CntW-1:0] cnt;
    logic [9:0]      cand;
`else
    typedef enum logic [0:0] {
        StIdle,
        StWaitRel
    } state_e;
`endif

    state_e     state;
    logic [9:0] sync1;
    logic [9:0] sync2;
    logic [9:0] act;
    logic       capture;
    logic [9:0] cap_vec;

    // Lowest set index of a line vector; zero when no line is set.
    function automatic logic [3:0] lowest_index(input logic [9:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 9; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    // True when more than one bit is set (clearing the lowest set bit leaves something).
    function automatic logic more_than_one(input logic [9:0] v);
        return (v & (v - 10'd1)) != 10'd0;
    endfunction

    // Two-flop synchroniser for the asynchronous lines; released lines read as all ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 10'h3FF;
            sync2 <= 10'h3FF;
        end else begin
            sync1 <= line_n;
            sync2 <= sync1;
        end
    end

    // Active lines and the capture decision for this cycle.
    always_comb begin
        act     = ~sync2 & {10{enable}};
        capture = 1'b0;
        cap_vec = 10'd0;
`ifdef DECIMAL_LINE_ENCODER_DEBOUNCE_EN
        if (state == StDebounce && act != 10'd0 && act == cand && cnt == CntMax) begin
            capture = 1'b1;
        end
        cap_vec = cand;
`else
        if (state == StIdle && act != 10'd0) begin
            capture = 1'b1;
        end
        cap_vec = act;
`endif
    end

`ifdef DECIMAL_LINE_ENCODER_DEBOUNCE_EN
    // Press/release debounce: a pattern must hold for DEBOUNCE_CYCLES to capture, and the
    // lines must read idle for DEBOUNCE_CYCLES before a new press is considered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= StIdle;
            cnt   <= '0;
            cand  <= 10'd0;
        end else begin
            case (state)
                StIdle: begin
                    if (act != 10'd0) begin
                        cand  <= act;
                        cnt   <= '0;
                        state <= StDebounce;
                    end
                end
                StDebounce: begin
                    if (act == 10'd0) begin
                        state <= StIdle;
                    end else if (act != cand) begin
                        cand <= act;
                        cnt  <= '0;
                    end else if (cnt == CntMax) begin
                        // Release count starts fresh so a full quiet window is needed.
                        cnt   <= '0;
                        state <= StWaitRel;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                StWaitRel: begin
                    if (act != 10'd0) begin
                        cnt <= '0;
                    end else if (cnt == CntMax) begin
                        cnt   <= '0;
                        state <= StIdle;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                default: begin
                    state <= StIdle;
                    cnt   <= '0;
                end
            endcase
        end
    end
`else
    // Capture on the first active cycle, then wait for one idle cycle before re-arming.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= StIdle;
        end else begin
            case (state)
                StIdle: begin
                    if (act != 10'd0) begin
                        state <= StWaitRel;
                    end
                end
                StWaitRel: begin
                    if (act == 10'd0) begin
                        state <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end
`endif

    // Output register: capture loads code/multi, handshake consumes, overrun is sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            code    <= 4'd0;
            valid   <= 1'b0;
            multi   <= 1'b0;
            overrun <= 1'b0;
        end else if (capture) begin
            code  <= lowest_index(cap_vec);
            multi <= more_than_one(cap_vec);
            valid <= 1'b1;
            // A same-cycle accept consumes the old digit, so only an unaccepted one is lost.
            if (valid && !ready) begin
                overrun <= 1'b1;
            end
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decimal_line_encoder.sv
// Self-checking bench for decimal_line_encoder with a transaction-level reference model.
// Capture edges are scheduled from the press latency and release rules; the model then
// applies the handshake rules to predict valid/code/multi/overrun after every edge.

module tb_decimal_line_encoder;

    localparam int DB = 4;
`ifdef DECIMAL_LINE_ENCODER_DEBOUNCE_EN
    localparam int LAT = 3 + DB;
    localparam int REL = DB;
`else
    localparam int LAT = 3;
    localparam int REL = 1;
`endif

    logic       clk;
    logic       rst;
    logic [9:0] line_n;
    logic       enable;
    logic [3:0] code;
    logic       valid;
    logic       ready;
    logic       multi;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [3:0] m_code;
    logic       m_valid;
    logic       m_multi;
    logic       m_over;

    decimal_line_encoder #(
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .line_n (line_n),
        .enable (enable),
        .code   (code),
        .valid  (valid),
        .ready  (ready),
        .multi  (multi),
        .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] first_digit(input logic [9:0] pat);
        for (int i = 0; i < 10; i++) begin
            if (pat[i]) return 4'(i);
        end
        return 4'd0;
    endfunction

    // Behavioural M161: BCD in, one active-low line out for digits 0-9.
    function automatic logic [9:0] m161(input logic [3:0] bcd);
        logic [9:0] o;
        o = 10'h3FF;
        if (bcd < 4'd10) o[bcd] = 1'b0;
        return o;
    endfunction

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive ready (0, 1 or random), advance, update model, compare outputs.
    task automatic tick(input bit cap, input logic [9:0] pat, input int rmode);
        case (rmode)
            0: ready = 1'b0;
            1: ready = 1'b1;
            default: ready = 1'($urandom_range(0, 1));
        endcase
        @(posedge clk);
        #1;
        if (rst) begin
            m_code  = 4'd0;
            m_valid = 1'b0;
            m_multi = 1'b0;
            m_over  = 1'b0;
        end else if (cap) begin
            if (m_valid && !ready) m_over = 1'b1;
            m_code  = first_digit(pat);
            m_multi = ($countones(pat) > 1);
            m_valid = 1'b1;
        end else if (m_valid && ready) begin
            m_valid = 1'b0;
        end
        chk("valid", 10'(valid), 10'(m_valid));
        chk("code", 10'(code), 10'(m_code));
        chk("multi", 10'(multi), 10'(m_multi));
        chk("overrun", 10'(overrun), 10'(m_over));
    endtask

    // Apply a stable press from idle; capture is expected on edge LAT.
    task automatic press(input logic [9:0] pat, input int rmode, input int lastmode);
        line_n = ~pat;
        for (int k = 1; k <= LAT; k++) begin
            tick(k == LAT, pat, (k == LAT) ? lastmode : rmode);
        end
    endtask

    task automatic idle_ticks(input int n, input int rmode);
        for (int k = 0; k < n; k++) tick(1'b0, 10'd0, rmode);
    endtask

    task automatic release_lines(input int n, input int rmode);
        line_n = 10'h3FF;
        idle_ticks(n, rmode);
    endtask

    initial begin
        logic [9:0] pat;
        m_code  = 4'd0;
        m_valid = 1'b0;
        m_multi = 1'b0;
        m_over  = 1'b0;
        rst     = 1'b1;
        line_n  = 10'h3FF;
        enable  = 1'b1;
        ready   = 1'b0;

        // Reset state
        idle_ticks(2, 0);
        rst = 1'b0;
        idle_ticks(2, 0);

        // Digit 3 held with ready low, then a one-cycle ready pulse
        press(10'h008, 0, 0);
        idle_ticks(2, 0);
        idle_ticks(1, 1);
        release_lines(REL + 4, 0);

`ifdef DECIMAL_LINE_ENCODER_DEBOUNCE_EN
        // Bounce: two active cycles, one released, then stable; one capture from last interval
        line_n = ~10'h080;
        idle_ticks(2, 0);
        line_n = 10'h3FF;
        idle_ticks(1, 0);
        press(10'h080, 0, 0);
        idle_ticks(3, 1);
        release_lines(REL + 4, 2);

        // Release shorter than the debounce window does not re-arm
        press(10'h002, 2, 2);
        idle_ticks(2, 2);
        release_lines(REL - 1, 2);
        line_n = ~10'h010;
        idle_ticks(LAT + 3, 2);
        release_lines(REL + 4, 2);

        // Enable dropped mid-debounce: no capture
        line_n = ~10'h040;
        idle_ticks(3, 2);
        enable = 1'b0;
        idle_ticks(6, 2);
        line_n = 10'h3FF;
        idle_ticks(3, 2);
        enable = 1'b1;
        idle_ticks(2, 2);
`endif

        // Multi-press: lines 2 and 9
        press(10'h204, 0, 0);
        idle_ticks(1, 1);
        release_lines(REL + 4, 0);

        // Press with enable low is ignored
        enable = 1'b0;
        line_n = ~10'h020;
        idle_ticks(LAT + 4, 2);
        line_n = 10'h3FF;
        idle_ticks(3, 2);
        enable = 1'b1;
        idle_ticks(2, 2);

        // Overrun: digit 5 never consumed, digit 8 overwrites it
        idle_ticks(2, 1);
        press(10'h020, 0, 0);
        release_lines(REL + 4, 0);
        press(10'h100, 0, 0);
        line_n = 10'h3FF;
        idle_ticks(1, 0);
        // Reset with a pending digit clears everything
        rst = 1'b1;
        idle_ticks(1, 0);
        rst = 1'b0;
        idle_ticks(REL + 3, 0);

        // Capture in the same cycle as an accept: no overrun
        press(10'h020, 0, 0);
        release_lines(REL + 4, 0);
        press(10'h100, 0, 1);
        idle_ticks(1, 1);
        release_lines(REL + 4, 0);

        // Digit 9 with loopback through a behavioural M161
        press(10'h200, 0, 0);
        chk("m161_loop", m161(code), 10'h1FF);
        idle_ticks(1, 1);
        release_lines(REL + 4, 2);

        // Randomised press/hold/release transactions
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 1) == 0) begin
                pat = 10'd1 << $urandom_range(0, 9);
            end else begin
                pat = 10'($urandom_range(1, 1023));
            end
            press(pat, 2, 2);
            idle_ticks(int'($urandom_range(0, 4)), 2);
            release_lines(REL + 3 + int'($urandom_range(0, 3)), 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
